// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32 definitions for the memory stage.
//   XLEN          - datapath width (32)
//   MEMOP_*       - memory-op encodings carried on mem_op
//   mem_state_e   - memory-stage FSM state encoding
//   helpers       - op classification, byte-enable and store-data steering,
//                   alignment check (used only with MEM_MISALIGN_TRAP_EN)
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [3:0] MEMOP_NONE = 4'd0;
    localparam logic [3:0] MEMOP_LB   = 4'd1;
    localparam logic [3:0] MEMOP_LH   = 4'd2;
    localparam logic [3:0] MEMOP_LW   = 4'd3;
    localparam logic [3:0] MEMOP_LBU  = 4'd4;
    localparam logic [3:0] MEMOP_LHU  = 4'd5;
    localparam logic [3:0] MEMOP_SB   = 4'd6;
    localparam logic [3:0] MEMOP_SH   = 4'd7;
    localparam logic [3:0] MEMOP_SW   = 4'd8;

    typedef enum logic {
        StIdle,
        StBusy
    } mem_state_e;

    function automatic logic is_load(input logic [3:0] op);
        return (op == MEMOP_LB) || (op == MEMOP_LH) || (op == MEMOP_LW) ||
               (op == MEMOP_LBU) || (op == MEMOP_LHU);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == MEMOP_SB) || (op == MEMOP_SH) || (op == MEMOP_SW);
    endfunction

    // Loads and stores share the same lane masks; misaligned low bits are
    // simply not looked at (halfword uses addr[1], word uses neither).
    function automatic logic [3:0] byte_en(input logic [3:0] op, input logic [1:0] addr);
        logic [3:0] be;
        be = 4'b0000;
        case (op)
            MEMOP_LB, MEMOP_LBU, MEMOP_SB: be = 4'b0001 << addr;
            MEMOP_LH, MEMOP_LHU, MEMOP_SH: be = addr[1] ? 4'b1100 : 4'b0011;
            MEMOP_LW, MEMOP_SW:            be = 4'b1111;
            default:                       be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate store data across lanes so the slave just honours byte enables.
    function automatic logic [XLEN-1:0] store_data(input logic [3:0] op,
                                                   input logic [XLEN-1:0] sdata);
        logic [XLEN-1:0] wd;
        case (op)
            MEMOP_SB: wd = {4{sdata[7:0]}};
            MEMOP_SH: wd = {2{sdata[15:0]}};
            default:  wd = sdata;
        endcase
        return wd;
    endfunction

    function automatic logic misaligned(input logic [3:0] op, input logic [1:0] addr);
        logic m;
        case (op)
            MEMOP_LH, MEMOP_LHU, MEMOP_SH: m = addr[0];
            MEMOP_LW, MEMOP_SW:            m = (addr != 2'b00);
            default:                       m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: combinational load-data extraction and extension.
//   rdata_i [31:0] - raw word returned by the data bus
//   addr_i  [1:0]  - low effective-address bits selecting the byte/half
//   op_i    [3:0]  - MEMOP_* code; LB/LH sign-extend, LBU/LHU zero-extend
//   data_o  [31:0] - value to write back
module mem_load_align
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] rdata_i,
    input  logic [1:0]      addr_i,
    input  logic [3:0]      op_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[7:0];
        case (addr_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        data_o = rdata_i;
        case (op_i)
            MEMOP_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
            MEMOP_LBU: data_o = {24'h0, byte_sel};
            MEMOP_LH:  data_o = {{16{half_sel[15]}}, half_sel};
            MEMOP_LHU: data_o = {16'h0, half_sel};
            default:   data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: RV32 memory-access pipeline stage.
//   Consumes the EX/MEM outputs (mem_*), runs one req/ack data-bus transaction
//   per load/store, and registers the writeback triple (wb_*). stall_req holds
//   upstream while a memory op is pending; upstream keeps mem_* stable then.
// Ports:
//   clk, rst                        - clock, synchronous active-high reset
//   mem_wd/mem_wreg/mem_wdata       - dest reg, write enable, ALU result/address
//   mem_op/mem_sdata                - MEMOP_* code, store data
//   stall_req                       - combinational upstream hold
//   dbus_req/we/addr/be/wdata       - registered bus request fields
//   dbus_ack/dbus_rdata             - bus completion, read data
//   wb_wd/wb_wreg/wb_wdata          - registered writeback triple
//   misalign_exc/misalign_addr      - only when MEM_MISALIGN_TRAP_EN is defined
// Configuration:
//   MEM_MISALIGN_TRAP_EN - trap misaligned half/word accesses instead of
//                          silently aligning them down.
module mem_stage
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      mem_wd,
    input  logic            mem_wreg,
    input  logic [XLEN-1:0] mem_wdata,
    input  logic [3:0]      mem_op,
    input  logic [XLEN-1:0] mem_sdata,
    output logic            stall_req,
    output logic            dbus_req,
    output logic            dbus_we,
    output logic [XLEN-1:0] dbus_addr,
    output logic [3:0]      dbus_be,
    output logic [XLEN-1:0] dbus_wdata,
    input  logic            dbus_ack,
    input  logic [XLEN-1:0] dbus_rdata,
    output logic [4:0]      wb_wd,
    output logic            wb_wreg,
    output logic [XLEN-1:0] wb_wdata
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic            misalign_exc,
    output logic [XLEN-1:0] misalign_addr
`endif
);

    mem_state_e      state_q;
    logic            dbus_req_q;
    logic            dbus_we_q;
    logic [XLEN-1:0] dbus_addr_q;
    logic [3:0]      dbus_be_q;
    logic [XLEN-1:0] dbus_wdata_q;
    logic [4:0]      wb_wd_q;
    logic            wb_wreg_q;
    logic [XLEN-1:0] wb_wdata_q;

    logic            op_load;
    logic            op_mem;
    logic            trap;
    logic [XLEN-1:0] load_data;

    assign op_load = is_load(mem_op);
    assign op_mem  = op_load | is_store(mem_op);

`ifdef MEM_MISALIGN_TRAP_EN
    logic            misalign_exc_q;
    logic [XLEN-1:0] misalign_addr_q;

    assign trap          = op_mem && misaligned(mem_op, mem_wdata[1:0]);
    assign misalign_exc  = misalign_exc_q;
    assign misalign_addr = misalign_addr_q;
`else
    assign trap = 1'b0;
`endif

    mem_load_align u_load_align (
        .rdata_i (dbus_rdata),
        .addr_i  (mem_wdata[1:0]),
        .op_i    (mem_op),
        .data_o  (load_data)
    );

    // A trapped access completes in IDLE, so it must not stall.
    always_comb begin
        stall_req = 1'b0;
        unique case (state_q)
            StIdle:  stall_req = op_mem && !trap;
            StBusy:  stall_req = !dbus_ack;
            default: stall_req = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            dbus_req_q   <= 1'b0;
            dbus_we_q    <= 1'b0;
            dbus_addr_q  <= '0;
            dbus_be_q    <= 4'b0000;
            dbus_wdata_q <= '0;
            wb_wd_q      <= 5'd0;
            wb_wreg_q    <= 1'b0;
            wb_wdata_q   <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_exc_q  <= 1'b0;
            misalign_addr_q <= '0;
`endif
        end else begin
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_exc_q <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (!op_mem) begin
                        wb_wd_q    <= mem_wd;
                        wb_wreg_q  <= mem_wreg;
                        wb_wdata_q <= mem_wdata;
                    end else if (trap) begin
                        wb_wreg_q <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
                        misalign_exc_q  <= 1'b1;
                        misalign_addr_q <= mem_wdata;
`endif
                    end else begin
                        state_q      <= StBusy;
                        dbus_req_q   <= 1'b1;
                        dbus_we_q    <= !op_load;
                        dbus_addr_q  <= {mem_wdata[XLEN-1:2], 2'b00};
                        dbus_be_q    <= byte_en(mem_op, mem_wdata[1:0]);
                        dbus_wdata_q <= store_data(mem_op, mem_sdata);
                        wb_wreg_q    <= 1'b0;
                    end
                end
                StBusy: begin
                    if (dbus_ack) begin
                        state_q    <= StIdle;
                        dbus_req_q <= 1'b0;
                        wb_wd_q    <= mem_wd;
                        wb_wreg_q  <= op_load & mem_wreg;
                        if (op_load) begin
                            wb_wdata_q <= load_data;
                        end
                    end else begin
                        wb_wreg_q <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign dbus_req   = dbus_req_q;
    assign dbus_we    = dbus_we_q;
    assign dbus_addr  = dbus_addr_q;
    assign dbus_be    = dbus_be_q;
    assign dbus_wdata = dbus_wdata_q;
    assign wb_wd      = wb_wd_q;
    assign wb_wreg    = wb_wreg_q;
    assign wb_wdata   = wb_wdata_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage.
module tb_mem_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_op;
    logic [31:0] mem_sdata;
    logic        stall_req;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign_exc;
    logic [31:0] misalign_addr;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk        (clk),
        .rst        (rst),
        .mem_wd     (mem_wd),
        .mem_wreg   (mem_wreg),
        .mem_wdata  (mem_wdata),
        .mem_op     (mem_op),
        .mem_sdata  (mem_sdata),
        .stall_req  (stall_req),
        .dbus_req   (dbus_req),
        .dbus_we    (dbus_we),
        .dbus_addr  (dbus_addr),
        .dbus_be    (dbus_be),
        .dbus_wdata (dbus_wdata),
        .dbus_ack   (dbus_ack),
        .dbus_rdata (dbus_rdata),
        .wb_wd      (wb_wd),
        .wb_wreg    (wb_wreg),
        .wb_wdata   (wb_wdata)
`ifdef MEM_MISALIGN_TRAP_EN
        ,
        .misalign_exc  (misalign_exc),
        .misalign_addr (misalign_addr)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_op    = MEMOP_NONE;
        mem_wreg  = 1'b0;
        mem_wd    = 5'd0;
        mem_wdata = 32'h0;
        mem_sdata = 32'h0;
        dbus_ack  = 1'b0;
    endtask

    // One full transaction: issue, hold for 'waits' unacked BUSY cycles, then
    // ack with 'rdata' and check the writeback. Leaves inputs idle.
    task automatic do_mem(input string tag, input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [31:0] rdata,
                          input int waits, input logic [4:0] wd, input logic wreg,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic exp_we, input logic [31:0] exp_bus_wdata,
                          input logic exp_wb_wreg, input logic [31:0] exp_wb_wdata);
        mem_op    = op;
        mem_wdata = addr;
        mem_sdata = sdata;
        mem_wd    = wd;
        mem_wreg  = wreg;
        #1;
        check({tag, ".issue_stall"}, stall_req, 1);
        step();
        for (int i = 0; i <= waits; i++) begin
            if (i == waits) begin
                dbus_ack   = 1'b1;
                dbus_rdata = rdata;
            end
            #1;
            check({tag, ".req"}, dbus_req, 1);
            check({tag, ".addr"}, dbus_addr, exp_addr);
            check({tag, ".be"}, dbus_be, exp_be);
            check({tag, ".we"}, dbus_we, exp_we);
            if (exp_we) check({tag, ".bus_wdata"}, dbus_wdata, exp_bus_wdata);
            check({tag, ".busy_wreg"}, wb_wreg, 0);
            check({tag, ".busy_stall"}, stall_req, (i == waits) ? 0 : 1);
            step();
        end
        dbus_ack = 1'b0;
        check({tag, ".req_drop"}, dbus_req, 0);
        check({tag, ".wb_wreg"}, wb_wreg, exp_wb_wreg);
        if (exp_wb_wreg) begin
            check({tag, ".wb_wd"}, wb_wd, wd);
            check({tag, ".wb_wdata"}, wb_wdata, exp_wb_wdata);
        end
        idle_inputs();
    endtask

    initial begin
        rst        = 1'b1;
        dbus_rdata = 32'h0;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst.req", dbus_req, 0);
        check("rst.addr", dbus_addr, 0);
        check("rst.be", dbus_be, 0);
        check("rst.wb_wreg", wb_wreg, 0);
        check("rst.wb_wdata", wb_wdata, 0);
        check("rst.stall", stall_req, 0);

        // Non-memory op: one-cycle pass-through, never stalls.
        mem_wd    = 5'd5;
        mem_wreg  = 1'b1;
        mem_wdata = 32'h0000_1234;
        #1;
        check("alu.stall", stall_req, 0);
        step();
        check("alu.wb_wd", wb_wd, 5);
        check("alu.wb_wreg", wb_wreg, 1);
        check("alu.wb_wdata", wb_wdata, 32'h0000_1234);
        check("alu.req", dbus_req, 0);
        idle_inputs();

        // Ack while idle must not disturb anything.
        dbus_ack = 1'b1;
        step();
        dbus_ack = 1'b0;
        check("idle_ack.req", dbus_req, 0);
        check("idle_ack.wreg", wb_wreg, 0);
        step();

        do_mem("lb", MEMOP_LB, 32'h0000_0103, 32'h0, 32'h80FF_FFFF, 0, 5'd7, 1'b1,
               32'h0000_0100, 4'b1000, 1'b0, 32'h0, 1'b1, 32'hFFFF_FF80);
        do_mem("sh", MEMOP_SH, 32'h0000_0202, 32'hABCD_1234, 32'h0, 3, 5'd0, 1'b0,
               32'h0000_0200, 4'b1100, 1'b1, 32'h1234_1234, 1'b0, 32'h0);
        // Back-to-back LHU then LW: one idle cycle between requests.
        do_mem("lhu", MEMOP_LHU, 32'h0000_0402, 32'h0, 32'h8001_5555, 0, 5'd3, 1'b1,
               32'h0000_0400, 4'b1100, 1'b0, 32'h0, 1'b1, 32'h0000_8001);
        check("b2b.gap_req", dbus_req, 0);
        do_mem("lw", MEMOP_LW, 32'h0000_0500, 32'h0, 32'hDEAD_BEEF, 0, 5'd4, 1'b1,
               32'h0000_0500, 4'b1111, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
        do_mem("lh", MEMOP_LH, 32'h0000_0000, 32'h0, 32'h1234_8001, 1, 5'd6, 1'b1,
               32'h0000_0000, 4'b0011, 1'b0, 32'h0, 1'b1, 32'hFFFF_8001);
        do_mem("lbu", MEMOP_LBU, 32'h0000_0101, 32'h0, 32'h0000_9A00, 0, 5'd8, 1'b1,
               32'h0000_0100, 4'b0010, 1'b0, 32'h0, 1'b1, 32'h0000_009A);
        do_mem("sb", MEMOP_SB, 32'h0000_0003, 32'h1122_3355, 32'h0, 0, 5'd0, 1'b0,
               32'h0000_0000, 4'b1000, 1'b1, 32'h5555_5555, 1'b0, 32'h0);
        do_mem("sw", MEMOP_SW, 32'h0000_0704, 32'hCAFE_F00D, 32'h0, 2, 5'd0, 1'b0,
               32'h0000_0704, 4'b1111, 1'b1, 32'hCAFE_F00D, 1'b0, 32'h0);

        // Reset during BUSY abandons the transaction; late ack is ignored.
        mem_op    = MEMOP_LW;
        mem_wdata = 32'h0000_0600;
        mem_wd    = 5'd9;
        mem_wreg  = 1'b1;
        step();
        check("rstbusy.req_before", dbus_req, 1);
        rst = 1'b1;
        idle_inputs();
        step();
        rst = 1'b0;
        check("rstbusy.req", dbus_req, 0);
        check("rstbusy.addr", dbus_addr, 0);
        check("rstbusy.be", dbus_be, 0);
        check("rstbusy.wreg", wb_wreg, 0);
        check("rstbusy.stall", stall_req, 0);
        dbus_ack   = 1'b1;
        dbus_rdata = 32'h5A5A_5A5A;
        step();
        dbus_ack = 1'b0;
        check("late_ack.wreg", wb_wreg, 0);
        check("late_ack.wdata", wb_wdata, 0);
        check("late_ack.req", dbus_req, 0);

`ifdef MEM_MISALIGN_TRAP_EN
        mem_op    = MEMOP_LW;
        mem_wdata = 32'h0000_0301;
        mem_wd    = 5'd10;
        mem_wreg  = 1'b1;
        #1;
        check("mis.stall", stall_req, 0);
        step();
        idle_inputs();
        check("mis.exc", misalign_exc, 1);
        check("mis.addr", misalign_addr, 32'h0000_0301);
        check("mis.req", dbus_req, 0);
        check("mis.wreg", wb_wreg, 0);
        step();
        check("mis.exc_pulse", misalign_exc, 0);
        check("mis.req_after", dbus_req, 0);
`else
        do_mem("lw_mis", MEMOP_LW, 32'h0000_0301, 32'h0, 32'h0102_0304, 0, 5'd10, 1'b1,
               32'h0000_0300, 4'b1111, 1'b0, 32'h0, 1'b1, 32'h0102_0304);
        do_mem("lh_mis", MEMOP_LH, 32'h0000_0203, 32'h0, 32'hF00F_0000, 0, 5'd11, 1'b1,
               32'h0000_0200, 4'b1100, 1'b0, 32'h0, 1'b1, 32'hFFFF_F00F);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
